// File: rtl/scalar_alu_pipe_if.sv
// Issue/result handshake bundle for scalar_alu_pipe.
// The ALU takes the slave modport; the issuing and consuming side takes the master modport.
interface scalar_alu_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_control;
    logic [2*DATA_W-1:0] in_s1;
    logic [2*DATA_W-1:0] in_s2;
    logic [2*DATA_W-1:0] in_exec;
    logic                in_scc;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [2*DATA_W-1:0] out_data;
    logic                out_scc;
    logic                out_scc_wr;
    logic                out_illegal;
    logic [TAG_W-1:0]    out_tag;

    modport slave (
        input  in_valid, in_control, in_s1, in_s2, in_exec, in_scc, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_scc, out_scc_wr, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_control, in_s1, in_s2, in_exec, in_scc, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_scc, out_scc_wr, out_illegal, out_tag
    );
endinterface

// File: rtl/scalar_alu_pipe.sv
// Registered, handshaked scalar ALU: single-cycle SOPP/SOP1/SOP2/SOPC/SOPK ops plus an
// iterative shift-add multiplier, results returned in acceptance order through one output register.
module scalar_alu_pipe #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int MUL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    scalar_alu_pipe_if.slave  bus,
    output logic              busy
);
    localparam int W     = DATA_W;
    localparam int SH_W  = $clog2(W);
    localparam int STEPS = W / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_nxt;

    logic [7:0]       fmt;
    logic [23:0]      op;
    logic [W-1:0]     a, b;
    logic [SH_W-1:0]  sh;
    logic [W:0]       add_w, addc_w, sub_w, subb_w;
    logic             add_ovf, sub_ovf, eq, lt_s, lt_u;

    logic [W-1:0]     lo;
    logic [2*W-1:0]   wide_data;
    logic             wide, scc_nz;
    logic [2*W-1:0]   res_data;
    logic             res_scc, res_scc_wr, res_illegal, res_is_mul;

    logic [W-1:0]     mul_acc, mul_mcand, mul_mplier, mul_partial;
    logic [CNT_W-1:0] mul_cnt;
    logic [TAG_W-1:0] mul_tag;

    logic             out_free, accept, mul_done, res_load;

    assign fmt = bus.in_control[31:24];
    assign op  = bus.in_control[23:0];
    assign a   = bus.in_s1[W-1:0];
    assign b   = bus.in_s2[W-1:0];
    assign sh  = b[SH_W-1:0];

    // Carry/borrow fall out of bit W of the zero-extended sums and differences.
    assign add_w   = {1'b0, a} + {1'b0, b};
    assign addc_w  = add_w + {{W{1'b0}}, bus.in_scc};
    assign sub_w   = {1'b0, a} - {1'b0, b};
    assign subb_w  = sub_w - {{W{1'b0}}, bus.in_scc};
    assign add_ovf = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
    assign sub_ovf = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
    assign eq      = (a == b);
    assign lt_s    = ($signed(a) < $signed(b));
    assign lt_u    = (a < b);

    always_comb begin
        lo          = '0;
        wide        = 1'b0;
        wide_data   = '0;
        scc_nz      = 1'b0;
        res_data    = '0;
        res_scc     = 1'b0;
        res_scc_wr  = 1'b0;
        res_illegal = 1'b0;
        res_is_mul  = 1'b0;
        case (fmt)
            8'h01: begin
                if (op inside {24'h02, 24'h04, 24'h05, 24'h06, 24'h08}) begin
                    wide      = 1'b1;
                    wide_data = bus.in_s1 + (bus.in_s2 << 2) + (2*W)'(4);
                end else begin
                    res_illegal = 1'b1;
                end
            end
            8'h02: begin
                case (op)
                    24'h03: lo = a;
                    24'h04: begin wide = 1'b1; wide_data = bus.in_s1; end
                    24'h07: begin lo = ~a; scc_nz = 1'b1; end
                    24'h24: begin wide = 1'b1; wide_data = bus.in_s1 & bus.in_exec; scc_nz = 1'b1; end
                    default: res_illegal = 1'b1;
                endcase
            end
            8'h04: begin
                res_scc_wr = 1'b1;
                case (op)
                    24'h00, 24'h06: res_scc = eq;
                    24'h01, 24'h07: res_scc = !eq;
                    24'h02:         res_scc = !lt_s && !eq;
                    24'h03:         res_scc = !lt_s;
                    24'h04:         res_scc = lt_s;
                    24'h05:         res_scc = lt_s || eq;
                    24'h08:         res_scc = !lt_u && !eq;
                    24'h09:         res_scc = !lt_u;
                    24'h0A:         res_scc = lt_u;
                    24'h0B:         res_scc = lt_u || eq;
                    default:        res_illegal = 1'b1;
                endcase
            end
            8'h08: begin
                case (op)
                    24'h00: begin lo = add_w[W-1:0];  res_scc = add_w[W];   res_scc_wr = 1'b1; end
                    24'h01: begin lo = sub_w[W-1:0];  res_scc = sub_w[W];   res_scc_wr = 1'b1; end
                    24'h02: begin lo = add_w[W-1:0];  res_scc = add_ovf;    res_scc_wr = 1'b1; end
                    24'h03: begin lo = sub_w[W-1:0];  res_scc = sub_ovf;    res_scc_wr = 1'b1; end
                    24'h04: begin lo = addc_w[W-1:0]; res_scc = addc_w[W];  res_scc_wr = 1'b1; end
                    24'h05: begin lo = subb_w[W-1:0]; res_scc = subb_w[W];  res_scc_wr = 1'b1; end
                    24'h07: begin lo = lt_u ? a : b;  res_scc = lt_u;       res_scc_wr = 1'b1; end
                    24'h09: begin lo = (!lt_u && !eq) ? a : b; res_scc = !lt_u && !eq; res_scc_wr = 1'b1; end
                    24'h0E: begin lo = a & b; scc_nz = 1'b1; end
                    24'h0F: begin wide = 1'b1; wide_data = bus.in_s1 & bus.in_s2; scc_nz = 1'b1; end
                    24'h10: begin lo = a | b; scc_nz = 1'b1; end
                    24'h15: begin wide = 1'b1; wide_data = bus.in_s1 & ~bus.in_s2; scc_nz = 1'b1; end
                    24'h1E: begin lo = a << sh; scc_nz = 1'b1; end
                    24'h20: begin lo = a >> sh; scc_nz = 1'b1; end
                    24'h22: begin lo = $signed(a) >>> sh; scc_nz = 1'b1; end
                    24'h26: res_is_mul = 1'b1;
                    default: res_illegal = 1'b1;
                endcase
            end
            8'h10: begin
                case (op)
                    24'h00: lo = b;
                    24'h0F: begin lo = add_w[W-1:0]; res_scc = add_ovf; res_scc_wr = 1'b1; end
                    24'h10: res_is_mul = 1'b1;
                    default: res_illegal = 1'b1;
                endcase
            end
            default: res_illegal = 1'b1;
        endcase
        if (res_illegal) begin
            res_scc    = 1'b0;
            res_scc_wr = 1'b0;
        end else begin
            res_data = wide ? wide_data : {{W{1'b0}}, lo};
            if (scc_nz) begin
                res_scc_wr = 1'b1;
                res_scc    = |res_data;
            end
        end
    end

    // One radix-2^MUL_BITS digit of the multiplier, built as shifted adds of the multiplicand.
    always_comb begin
        mul_partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mul_mplier[i]) mul_partial = mul_partial + (mul_mcand << i);
        end
    end

    assign out_free     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_done     = (state == MUL) && (mul_cnt == CNT_W'(1)) && out_free;
    assign res_load     = (accept && !res_is_mul) || mul_done;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && res_is_mul) state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last digit is folded straight into the output register, so it is held back while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_tag    <= '0;
        end else if (accept && res_is_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= a;
            mul_mplier <= b;
            mul_cnt    <= CNT_W'(STEPS);
            mul_tag    <= bus.in_tag;
        end else if ((state == MUL) && (mul_cnt > CNT_W'(1))) begin
            mul_acc    <= mul_acc + mul_partial;
            mul_mcand  <= mul_mcand << MUL_BITS;
            mul_mplier <= mul_mplier >> MUL_BITS;
            mul_cnt    <= mul_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_scc     <= 1'b0;
            bus.out_scc_wr  <= 1'b0;
            bus.out_illegal <= 1'b0;
            bus.out_tag     <= '0;
        end else if (res_load) begin
            bus.out_valid <= 1'b1;
            if (mul_done) begin
                bus.out_data    <= {{W{1'b0}}, mul_acc + mul_partial};
                bus.out_scc     <= 1'b0;
                bus.out_scc_wr  <= 1'b0;
                bus.out_illegal <= 1'b0;
                bus.out_tag     <= mul_tag;
            end else begin
                bus.out_data    <= res_data;
                bus.out_scc     <= res_scc;
                bus.out_scc_wr  <= res_scc_wr;
                bus.out_illegal <= res_illegal;
                bus.out_tag     <= bus.in_tag;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
